// File: rtl/audio_spi_pkg.sv
// Shared constants and FSM state encoding for the audio SPI slave.
package audio_spi_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TX_DEPTH   = 4;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/audio_spi_if.sv
// SPI pin bundle plus the fabric-side RX/TX handshake of the audio SPI slave.
interface audio_spi_if
  import audio_spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  SPI_SCK;
  logic                  SPI_SS_N;
  logic                  SPI_MOSI;
  logic                  SPI_MISO;
  logic                  SPI_MISO_OE;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_VALID;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_WR;
  logic                  TX_FULL;
  logic                  TX_UNDERRUN;

  modport slave (
    input  SPI_SCK, SPI_SS_N, SPI_MOSI, TX_DATA, TX_WR,
    output SPI_MISO, SPI_MISO_OE, RX_DATA, RX_VALID, TX_FULL, TX_UNDERRUN
  );

  modport master (
    output SPI_SCK, SPI_SS_N, SPI_MOSI, TX_DATA, TX_WR,
    input  SPI_MISO, SPI_MISO_OE, RX_DATA, RX_VALID, TX_FULL, TX_UNDERRUN
  );

endinterface

// File: rtl/audio_spi_txfifo.sv
// First-word-fall-through TX FIFO; a write while full is accepted only alongside a pop.
module audio_spi_txfifo
  import audio_spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_TX_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  do_wr;
  logic                  do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_wr    = wr_en && (!full || rd_en);
    do_rd    = rd_en && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/audio_spi_slave.sv
// SPI mode-0 slave clocked entirely by FAB_CLK; the SPI pins are oversampled through synchronizers.
module audio_spi_slave
  import audio_spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TX_DEPTH   = DEF_TX_DEPTH
) (
  input  logic       FAB_CLK,
  input  logic       FAB_RESET,
  audio_spi_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  spi_state_e            state_q, state_d;
  logic [2:0]            sck_q, sck_d;
  logic [2:0]            ss_q, ss_d;
  logic [1:0]            mosi_q, mosi_d;
  logic [1:0]            fill_q, fill_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  rx_done_q, rx_done_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic                  pend_empty_q, pend_empty_d;
  logic                  underrun_q, underrun_d;

  logic                  sck_rise, sck_fall, ss_rise, ss_fall;
  logic                  underrun_set;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data, load_word;

  audio_spi_txfifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (TX_DEPTH)
  ) u_txfifo (
    .clk    (FAB_CLK),
    .rst    (FAB_RESET),
    .wr_en  (bus.TX_WR),
    .wr_data(bus.TX_DATA),
    .rd_en  (fifo_pop),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign sck_rise  =  sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] &  sck_q[2];
  assign ss_rise   =  ss_q[1]  & ~ss_q[2];
  assign ss_fall   = ~ss_q[1]  &  ss_q[2];
  assign load_word = fifo_empty ? '0 : fifo_rd_data;

  // fill_q holds ARM until the SS_N synchronizer carries real pin samples, not reset values.
  always_comb begin
    state_d      = state_q;
    sck_d        = {sck_q[1:0], bus.SPI_SCK};
    ss_d         = {ss_q[1:0], bus.SPI_SS_N};
    mosi_d       = {mosi_q[0], bus.SPI_MOSI};
    fill_d       = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    cnt_d        = cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    tx_shift_d   = tx_shift_q;
    rx_done_d    = 1'b0;
    rx_valid_d   = rx_done_q;
    miso_d       = miso_q;
    oe_d         = oe_q;
    pend_empty_d = pend_empty_q;
    underrun_set = 1'b0;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_ARM: begin
        if (fill_q == 2'd2 && ss_q[1]) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ss_fall) begin
          state_d      = ST_SHIFT;
          fifo_pop     = 1'b1;
          miso_d       = load_word[DATA_WIDTH-1];
          oe_d         = 1'b1;
          tx_shift_d   = load_word << 1;
          pend_empty_d = fifo_empty;
          cnt_d        = '0;
          rx_shift_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d      = ST_IDLE;
          miso_d       = 1'b0;
          oe_d         = 1'b0;
          cnt_d        = '0;
          pend_empty_d = 1'b0;
        end else begin
          // Underrun is flagged only once a frame loaded from an empty FIFO actually clocks.
          if (sck_rise) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_q[1]};
            if (cnt_q == '0 && pend_empty_q) begin
              underrun_set = 1'b1;
              pend_empty_d = 1'b0;
            end
            if (cnt_q == CNT_LAST) begin
              cnt_d        = '0;
              rx_data_d    = {rx_shift_q[DATA_WIDTH-2:0], mosi_q[1]};
              rx_done_d    = 1'b1;
              fifo_pop     = 1'b1;
              tx_shift_d   = load_word;
              pend_empty_d = fifo_empty;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          if (sck_fall) begin
            miso_d     = tx_shift_q[DATA_WIDTH-1];
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase

    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (bus.TX_WR) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      state_q      <= ST_ARM;
      sck_q        <= 3'b000;
      ss_q         <= 3'b111;
      mosi_q       <= 2'b00;
      fill_q       <= 2'd0;
      cnt_q        <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      tx_shift_q   <= '0;
      rx_done_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      pend_empty_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_q        <= sck_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      tx_shift_q   <= tx_shift_d;
      rx_done_q    <= rx_done_d;
      rx_valid_q   <= rx_valid_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      pend_empty_q <= pend_empty_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.SPI_MISO    = miso_q;
  assign bus.SPI_MISO_OE = oe_q;
  assign bus.RX_DATA     = rx_data_q;
  assign bus.RX_VALID    = rx_valid_q;
  assign bus.TX_FULL     = fifo_full;
  assign bus.TX_UNDERRUN = underrun_q;

endmodule
